// File: rtl/iq_pkg.sv
// Shared types for the collapsing issue queue: one entry per slot, oldest at index 0.
package iq_pkg;

  localparam int IQ_DATA_WIDTH = 32;
  localparam int IQ_TAG_WIDTH  = 6;

  typedef struct packed {
    logic                     valid;
    logic                     src_rdy;
    logic [IQ_TAG_WIDTH-1:0]  src_tag;
    logic [IQ_DATA_WIDTH-1:0] data;
  } iq_entry_t;

endpackage

// File: rtl/extend_first1.sv
// Thermometer expansion: every bit at or above the lowest set input bit is set.
module extend_first1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic acc;

  always_comb begin
    out_o = '0;
    acc   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      acc      = acc | in_i[i];
      out_o[i] = acc;
    end
  end

endmodule

// File: rtl/iq_slot.sv
// Next-state selection for one queue slot: hold, shift down from above, or take the
// enqueue write, then apply the wakeup compare on the resulting image.
module iq_slot
  import iq_pkg::*;
(
  input  iq_entry_t               cur_i,
  input  iq_entry_t               above_i,
  input  iq_entry_t               enq_i,
  input  logic                    shift_i,
  input  logic                    wr_en_i,
  input  logic                    wakeup_valid_i,
  input  logic [IQ_TAG_WIDTH-1:0] wakeup_tag_i,
  input  logic                    flush_i,
  output iq_entry_t               nxt_o
);

  iq_entry_t e;

  always_comb begin
    e = cur_i;
    if (shift_i) e = above_i;
    // The enqueue write lands in the post-shift image, so it overrides the shift-in.
    if (wr_en_i) e = enq_i;
    if (wakeup_valid_i && e.valid && (e.src_tag == wakeup_tag_i)) e.src_rdy = 1'b1;
    if (flush_i) begin
      e.valid   = 1'b0;
      e.src_rdy = 1'b0;
    end
    nxt_o = e;
  end

endmodule

// File: rtl/collapsing_iq.sv
// Age-ordered collapsing issue queue: oldest-ready select, compaction on issue,
// tag-broadcast wakeup. Slot 0 is always the oldest entry.
module collapsing_iq
  import iq_pkg::*;
#(
  parameter int N_ENTRIES  = 8,
  parameter int DATA_WIDTH = IQ_DATA_WIDTH,
  parameter int TAG_WIDTH  = IQ_TAG_WIDTH,
  localparam int CW        = $clog2(N_ENTRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_aL,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic [TAG_WIDTH-1:0]  enq_src_tag,
  input  logic                  enq_src_rdy,
  input  logic                  wakeup_valid,
  input  logic [TAG_WIDTH-1:0]  wakeup_tag,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic [CW-1:0]         count
);

  logic [N_ENTRIES-1:0]     valid_q, valid_d;
  logic [N_ENTRIES-1:0]     rdy_q, rdy_d;
  logic [IQ_TAG_WIDTH-1:0]  tag_q  [N_ENTRIES];
  logic [IQ_DATA_WIDTH-1:0] data_q [N_ENTRIES];
  logic [CW-1:0]            count_q, count_d;

  iq_entry_t cur [N_ENTRIES];
  iq_entry_t nxt [N_ENTRIES];
  iq_entry_t enq_entry;

  logic [N_ENTRIES-1:0]     cand, grant, ext, shift;
  logic [IQ_DATA_WIDTH-1:0] sel_data;
  logic                     deq_fire, enq_fire;
  logic [CW-1:0]            wr_idx;

  // Select: oldest ready entry from registered state only
  assign cand      = valid_q & rdy_q;
  assign grant     = cand & (~cand + N_ENTRIES'(1));
  assign deq_valid = |cand;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      sel_data = sel_data | (data_q[i] & {IQ_DATA_WIDTH{grant[i]}});
    end
  end

  assign deq_data  = DATA_WIDTH'(sel_data);
  assign enq_ready = (count_q < CW'(N_ENTRIES));
  assign deq_fire  = deq_valid & deq_ready;
  assign enq_fire  = enq_valid & enq_ready;
  assign wr_idx    = count_q - CW'(deq_fire);
  assign count     = count_q;

  extend_first1 #(.WIDTH(N_ENTRIES)) u_ext (
    .in_i  (grant),
    .out_o (ext)
  );

  assign shift = ext & {N_ENTRIES{deq_fire}};

  always_comb begin
    enq_entry.valid   = 1'b1;
    enq_entry.src_rdy = enq_src_rdy;
    enq_entry.src_tag = IQ_TAG_WIDTH'(enq_src_tag);
    enq_entry.data    = IQ_DATA_WIDTH'(enq_data);
  end

  // Compaction and enqueue: each slot chooses its next value
  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_slot
    iq_entry_t above;

    always_comb begin
      cur[g].valid   = valid_q[g];
      cur[g].src_rdy = rdy_q[g];
      cur[g].src_tag = tag_q[g];
      cur[g].data    = data_q[g];
    end

    if (g == N_ENTRIES - 1) begin : g_top
      assign above = '0;
    end else begin : g_mid
      assign above = cur[g+1];
    end

    iq_slot u_slot (
      .cur_i          (cur[g]),
      .above_i        (above),
      .enq_i          (enq_entry),
      .shift_i        (shift[g]),
      .wr_en_i        (enq_fire && (wr_idx == CW'(g))),
      .wakeup_valid_i (wakeup_valid),
      .wakeup_tag_i   (IQ_TAG_WIDTH'(wakeup_tag)),
      .flush_i        (flush),
      .nxt_o          (nxt[g])
    );

    assign valid_d[g] = nxt[g].valid;
    assign rdy_d[g]   = nxt[g].src_rdy;
  end

  assign count_d = flush ? '0 : (count_q + CW'(enq_fire) - CW'(deq_fire));

  // State update: control bits reset asynchronously, payload/tags never need reset
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      valid_q <= '0;
      rdy_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      tag_q[i]  <= nxt[i].src_tag;
      data_q[i] <= nxt[i].data;
    end
  end

endmodule
